// File: rtl/median_window_gen.sv
// Streaming 3x3 window generator for the median sorter: two line buffers plus a 3x3 shift window.
// Optional output register stage (2-cycle latency) when WIN_OUT_REG_EN is defined.
module median_window_gen #(
   parameter int DATA_SIZE = 8,
   parameter int IMG_WIDTH = 64,
   parameter int COL_BITS  = $clog2(IMG_WIDTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_SIZE-1:0] pixIn,
   input  logic                 pixValid,
   input  logic                 sof,
   output logic [DATA_SIZE-1:0] win0,
   output logic [DATA_SIZE-1:0] win1,
   output logic [DATA_SIZE-1:0] win2,
   output logic [DATA_SIZE-1:0] win3,
   output logic [DATA_SIZE-1:0] win4,
   output logic [DATA_SIZE-1:0] win5,
   output logic [DATA_SIZE-1:0] win6,
   output logic [DATA_SIZE-1:0] win7,
   output logic [DATA_SIZE-1:0] win8,
   output logic                 winValid
);

   localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(IMG_WIDTH - 1);

   logic [COL_BITS-1:0]                col_q, col_d, col_eff;
   logic [1:0]                         row_q, row_d, row_eff;
   logic [8:0][DATA_SIZE-1:0]          win_q, win_d;
   logic                               vld_q, vld_d;
   logic [DATA_SIZE-1:0]               top_px, mid_px;
   logic [8:0][DATA_SIZE-1:0]          win_out;
   logic                               vld_out;

   logic [DATA_SIZE-1:0] lb0 [IMG_WIDTH];
   logic [DATA_SIZE-1:0] lb1 [IMG_WIDTH];

   // sof re-homes the current pixel to c=0, r=0 before it is used anywhere
   always_comb begin
      col_eff = sof ? '0 : col_q;
      row_eff = sof ? 2'd0 : row_q;
      top_px  = lb1[col_eff];
      mid_px  = lb0[col_eff];
      col_d   = col_q;
      row_d   = row_q;
      win_d   = win_q;
      vld_d   = 1'b0;
      if (pixValid) begin
         if (col_eff == COL_LAST) begin
            col_d = '0;
            row_d = (row_eff == 2'd2) ? 2'd2 : row_eff + 2'd1;
         end else begin
            col_d = col_eff + 1'b1;
            row_d = row_eff;
         end
         win_d[0] = win_q[1];
         win_d[1] = win_q[2];
         win_d[2] = top_px;
         win_d[3] = win_q[4];
         win_d[4] = win_q[5];
         win_d[5] = mid_px;
         win_d[6] = win_q[7];
         win_d[7] = win_q[8];
         win_d[8] = pixIn;
         vld_d    = (row_eff == 2'd2) && (col_eff >= COL_BITS'(2));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_q <= '0;
         row_q <= 2'd0;
         win_q <= '0;
         vld_q <= 1'b0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
         win_q <= win_d;
         vld_q <= vld_d;
      end
   end

   // Line buffers are deliberately not reset; row/col qualification masks stale contents
   always_ff @(posedge clk) begin
      if (pixValid) begin
         lb1[col_eff] <= lb0[col_eff];
         lb0[col_eff] <= pixIn;
      end
   end

`ifdef WIN_OUT_REG_EN
   logic [8:0][DATA_SIZE-1:0] win_o_q;
   logic                      vld_o_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_o_q <= '0;
         vld_o_q <= 1'b0;
      end else begin
         win_o_q <= win_q;
         vld_o_q <= vld_q;
      end
   end

   assign win_out = win_o_q;
   assign vld_out = vld_o_q;
`else
   assign win_out = win_q;
   assign vld_out = vld_q;
`endif

   assign win0     = win_out[0];
   assign win1     = win_out[1];
   assign win2     = win_out[2];
   assign win3     = win_out[3];
   assign win4     = win_out[4];
   assign win5     = win_out[5];
   assign win6     = win_out[6];
   assign win7     = win_out[7];
   assign win8     = win_out[8];
   assign winValid = vld_out;

endmodule

// File: tb/tb_median_window_gen.sv
// Scoreboard bench for median_window_gen: expected windows come from a frame image kept by the driver.
module tb_median_window_gen;
   localparam int W  = 4;
   localparam int DW = 8;
`ifdef WIN_OUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          pixValid = 1'b0;
   logic          sof = 1'b0;
   logic [DW-1:0] pixIn = '0;
   logic [DW-1:0] win0, win1, win2, win3, win4, win5, win6, win7, win8;
   logic          winValid;

   median_window_gen #(.DATA_SIZE(DW), .IMG_WIDTH(W), .COL_BITS(2)) dut (
      .clk(clk), .rst(rst), .pixIn(pixIn), .pixValid(pixValid), .sof(sof),
      .win0(win0), .win1(win1), .win2(win2), .win3(win3), .win4(win4),
      .win5(win5), .win6(win6), .win7(win7), .win8(win8), .winValid(winValid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [71:0] w;
      int          t;
   } exp_t;

   exp_t        sbq[$];
   int          n_chk = 0;
   int          n_pass = 0;
   int          cyc = 0;
   int          rst_gen = 0;
   int          k = 0;
   logic [3:0]  hist = '0;
   logic [7:0]  fr [0:1023];
   logic [71:0] win_pk;

   assign win_pk = {win0, win1, win2, win3, win4, win5, win6, win7, win8};

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge rst) rst_gen++;
   always @(posedge clk or posedge rst) begin
      if (rst) hist <= '0;
      else     hist <= {hist[2:0], pixValid};
   end

   task automatic check_eq(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
   endtask

   function automatic logic [71:0] exp_win(input int r, input int c);
      return {fr[(r-2)*W+c-2], fr[(r-2)*W+c-1], fr[(r-2)*W+c],
              fr[(r-1)*W+c-2], fr[(r-1)*W+c-1], fr[(r-1)*W+c],
              fr[r*W+c-2],     fr[r*W+c-1],     fr[r*W+c]};
   endfunction

   task automatic drive_px(input logic [7:0] v, input bit s);
      int r, c;
      @(negedge clk);
      pixValid = 1'b1;
      pixIn    = v;
      sof      = s;
      if (s) k = 0;
      if (k < 1024) begin
         fr[k] = v;
         r = k / W;
         c = k % W;
         if (r >= 2 && c >= 2) sbq.push_back('{exp_win(r, c), cyc + LAT});
         k++;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         pixValid = 1'b0;
         sof      = 1'b0;
      end
   endtask

   // Output monitor: pops the scoreboard on every strobe and checks hold behaviour across gaps
   initial begin
      int          seen = 0;
      logic [71:0] last = '0;
      exp_t        e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (seen != rst_gen) begin
               seen = rst_gen;
               last = '0;
            end
            if (winValid) begin
               if (sbq.size() == 0) begin
                  check_eq("unexpected_win", 72'(winValid), 72'd0);
               end else begin
                  e = sbq.pop_front();
                  check_eq("win", win_pk, e.w);
                  check_eq("win_latency", 72'(cyc), 72'(e.t));
               end
            end
            if (hist[LAT-1] == 1'b0) begin
               check_eq("hold_win", win_pk, last);
               check_eq("gap_valid", 72'(winValid), 72'd0);
            end
            last = win_pk;
         end
      end
   end

   initial begin
      @(negedge clk);
      check_eq("reset_win", win_pk, 72'd0);
      check_eq("reset_valid", 72'(winValid), 72'd0);
      #7 rst = 1'b0;

      // basic frame
      for (int i = 0; i < 16; i++) drive_px(8'(i), i == 0);
      idle(3);

      // gaps on every other cycle
      for (int i = 0; i < 16; i++) begin
         drive_px(8'(i), i == 0);
         idle(1);
      end
      idle(3);

      // frame A aborted by sof at its pixel 11, frame B follows
      for (int i = 0; i < 11; i++) drive_px(8'(i + 50), i == 0);
      for (int i = 0; i < 16; i++) drive_px(8'(100 + i), i == 0);
      idle(3);

      // asynchronous reset during row 2, then restart without sof
      for (int i = 0; i < 10; i++) drive_px(8'(150 + i), i == 0);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check_eq("async_rst_win", win_pk, 72'd0);
      check_eq("async_rst_valid", 72'(winValid), 72'd0);
      sbq.delete();
      #1 rst = 1'b0;
      k = 0;
      for (int i = 0; i < 16; i++) drive_px(8'(200 + i), 1'b0);
      idle(3);

      // random pixels with random gaps over a taller frame
      for (int i = 0; i < 6 * W; i++) begin
         drive_px(8'($urandom_range(0, 255)), i == 0);
         if ($urandom_range(0, 1) == 1) idle(1);
      end
      idle(5);

      check_eq("scoreboard_empty", 72'(sbq.size()), 72'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed running required finished");
      $fatal(1);
   end
endmodule
